// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one outstanding load/store, programmable
// wait states, and a fault flag for misaligned or out-of-window accesses.
`timescale 1ns/1ps

module dmem_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    // Window size in bytes, one bit wider so the compare cannot overflow.
    localparam logic [32:0] LIMIT = 33'd4 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT, S_RESP} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  resp_valid_q;
    logic                  resp_err_q;
    logic [31:0]           resp_rdata_q;
    logic [31:0]           mem_q [DEPTH];

    logic [31:0]           off;
    logic                  fault;
    logic [DEPTH_LOG2-1:0] idx;

    // Addresses below BASE_ADDR wrap to large offsets and fault.
    assign off   = addr_q - BASE_ADDR;
    assign fault = (addr_q[1:0] != 2'b00) || ({1'b0, off} >= LIMIT);
    assign idx   = off[DEPTH_LOG2+1:2];

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_COMMIT;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= fault;
                    resp_rdata_q <= (!fault && !we_q) ? mem_q[idx] : 32'd0;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: the array is deliberately left out of reset; stored data survives rst.
    always_ff @(posedge clk) begin
        if (rst && state_q == S_COMMIT && we_q && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (1 and 4 wait states),
// expected completions queued at request time and checked on each response.
`timescale 1ns/1ps

module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_v        [2];
    logic        req_valid_v  [2];
    logic        req_ready_v  [2];
    logic        req_we_v     [2];
    logic [31:0] req_addr_v   [2];
    logic [31:0] req_wdata_v  [2];
    logic [3:0]  req_wstrb_v  [2];
    logic        resp_valid_v [2];
    logic        resp_ready_v [2];
    logic [31:0] resp_rdata_v [2];
    logic        resp_err_v   [2];

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst_v[0]),
        .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]), .req_we(req_we_v[0]),
        .req_addr(req_addr_v[0]), .req_wdata(req_wdata_v[0]), .req_wstrb(req_wstrb_v[0]),
        .resp_valid(resp_valid_v[0]), .resp_ready(resp_ready_v[0]),
        .resp_rdata(resp_rdata_v[0]), .resp_err(resp_err_v[0])
    );

    dmem_responder #(.WAIT_CYCLES(4)) u_dut_w4 (
        .clk(clk), .rst(rst_v[1]),
        .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]), .req_we(req_we_v[1]),
        .req_addr(req_addr_v[1]), .req_wdata(req_wdata_v[1]), .req_wstrb(req_wstrb_v[1]),
        .resp_valid(resp_valid_v[1]), .resp_ready(resp_ready_v[1]),
        .resp_rdata(resp_rdata_v[1]), .resp_err(resp_err_v[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // One full transaction on instance sel; hold = cycles of response backpressure.
    task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int hold, input int wait_cyc);
        exp_t e;
        int   lat;
        @(negedge clk);
        check("req_ready_idle", req_ready_v[sel], 1'b1);
        req_valid_v[sel] = 1'b1;
        req_we_v[sel]    = we;
        req_addr_v[sel]  = addr;
        req_wdata_v[sel] = wdata;
        req_wstrb_v[sel] = wstrb;
        sb.push_back('{exp_rdata, exp_err});
        @(posedge clk);
        #1;
        req_valid_v[sel] = 1'b0;
        req_we_v[sel]    = 1'b0;
        req_addr_v[sel]  = 32'h0;
        req_wdata_v[sel] = 32'h0;
        req_wstrb_v[sel] = 4'h0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (resp_valid_v[sel]) break;
            lat++;
        end
        check("resp_valid_seen", resp_valid_v[sel], 1'b1);
        check("latency", 32'(lat), 32'(wait_cyc + 1));
        check("req_ready_busy", req_ready_v[sel], 1'b0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_rdata", resp_rdata_v[sel], e.rdata);
            check("resp_err", resp_err_v[sel], e.err);
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", resp_valid_v[sel], 1'b1);
                check("hold_rdata", resp_rdata_v[sel], e.rdata);
                check("hold_err", resp_err_v[sel], e.err);
                check("hold_req_ready", req_ready_v[sel], 1'b0);
            end
        end
        resp_ready_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_v[sel] = 1'b0;
        @(negedge clk);
        check("post_hs_valid", resp_valid_v[sel], 1'b0);
        check("post_hs_ready", req_ready_v[sel], 1'b1);
        check("post_hs_err", resp_err_v[sel], 1'b0);
        check("post_hs_rdata", resp_rdata_v[sel], 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_v[s]        = 1'b0;
            req_valid_v[s]  = 1'b1;
            req_we_v[s]     = 1'b0;
            req_addr_v[s]   = 32'h8000_0010;
            req_wdata_v[s]  = 32'h0;
            req_wstrb_v[s]  = 4'h0;
            resp_ready_v[s] = 1'b1;
        end

        // Reset held with a request pending: nothing may be accepted or answered.
        repeat (3) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                check("rst_resp_valid", resp_valid_v[s], 1'b0);
                check("rst_resp_err", resp_err_v[s], 1'b0);
                check("rst_resp_rdata", resp_rdata_v[s], 32'h0);
            end
        end
        for (int s = 0; s < 2; s++) begin
            req_valid_v[s]  = 1'b0;
            resp_ready_v[s] = 1'b0;
            rst_v[s]        = 1'b1;
        end
        repeat (2) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                check("post_rst_ready", req_ready_v[s], 1'b1);
                check("post_rst_valid", resp_valid_v[s], 1'b0);
            end
        end

        // WAIT_CYCLES=1 instance
        txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 0, 1);
        txn(0, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 0, 1);
        txn(0, 1'b1, 32'h8000_0010, 32'h0000_AA00, 4'b0010, 32'h0,      1'b0, 0, 1);
        txn(0, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0, 5, 1);
        txn(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 0, 1);
        txn(0, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0, 0, 1);
        txn(0, 1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0,         1'b1, 0, 1);
        txn(0, 1'b1, 32'h8000_0012, 32'h1111_1111, 4'hF, 32'h0,         1'b1, 0, 1);
        txn(0, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0, 0, 1);
        txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1, 0, 1);
        txn(0, 1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 0, 1);
        txn(0, 1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 0, 1);
        txn(0, 1'b1, 32'h8000_0FFC, 32'h7700_0000, 4'b1000, 32'h0,      1'b0, 0, 1);
        txn(0, 1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h77FE_F00D, 1'b0, 0, 1);

        // WAIT_CYCLES=4 instance: pre-clear the word, then abandon a store in WAIT
        txn(1, 1'b1, 32'h8000_0020, 32'h0, 4'hF, 32'h0, 1'b0, 0, 4);
        @(negedge clk);
        req_valid_v[1] = 1'b1;
        req_we_v[1]    = 1'b1;
        req_addr_v[1]  = 32'h8000_0020;
        req_wdata_v[1] = 32'h1234_5678;
        req_wstrb_v[1] = 4'hF;
        @(posedge clk);
        #1;
        req_valid_v[1] = 1'b0;
        req_we_v[1]    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_v[1] = 1'b0;
        @(negedge clk);
        rst_v[1] = 1'b1;
        check("wait_rst_valid", resp_valid_v[1], 1'b0);
        repeat (8) begin
            @(negedge clk);
            check("wait_rst_no_resp", resp_valid_v[1], 1'b0);
            check("wait_rst_ready", req_ready_v[1], 1'b1);
        end
        txn(1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h0, 1'b0, 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
